// File: rtl/flt_pkg.sv
// Shared constants and state encoding for the FP16 normalize/round/pack stage.
package flt_pkg;
  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_INF = 31;

  // Bit positions inside the extended mantissa {carry, hidden, frac[9:0], G, R, S}
  localparam int CARRY = FRAC_W + 4;
  localparam int HID   = FRAC_W + 3;
  localparam int LSB   = 3;
  localparam int G     = 2;
  localparam int R     = 1;
  localparam int S     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/flt_round_pack.sv
// Combinational round-to-nearest-even, round-carry renormalize and FP16 packing.
module flt_round_pack
  import flt_pkg::*;
(
  input  logic                sign,
  input  logic [EXP_W:0]      exp,
  input  logic [FRAC_W+4:0]   mant,
  output logic [15:0]         result
);

  logic          inc;
  logic [11:0]   m12;
  logic [10:0]   m11;
  logic [EXP_W:0] exp_r;

  assign inc = mant[G] & (mant[R] | mant[S] | mant[LSB]);
  assign m12 = {1'b0, mant[HID:LSB]} + {11'b0, inc};

  always_comb begin
    m11   = m12[10:0];
    exp_r = exp;
    if (m12[11]) begin
      m11   = m12[11:1];
      exp_r = exp + 6'd1;
    end

    // A subnormal that rounds up into the hidden bit is already at exp 1.
    if (exp_r >= 6'(EXP_INF))
      result = {sign, 5'h1F, 10'h000};
    else if (!m11[FRAC_W])
      result = {sign, 5'h00, m11[FRAC_W-1:0]};
    else
      result = {sign, exp_r[EXP_W-1:0], m11[FRAC_W-1:0]};
  end

endmodule

// File: rtl/flt_norm_round.sv
// Sequential post-add normalize (one shift per cycle), round and pack stage.
//   state | meaning
//   IDLE  | waiting for start
//   NORM  | one normalize shift per cycle, or zero detect
//   ROUND | round and pack into result
//   DONE  | result valid, done held until next start
module flt_norm_round
  import flt_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_sign,
  input  logic [EXP_W:0]      in_exp,
  input  logic [FRAC_W+4:0]   in_mant,
  output logic                done,
  output logic [15:0]         result,
  output logic                busy
);

  state_t            state;
  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [FRAC_W+4:0] mant_q;
  logic [15:0]       packed_w;

  flt_round_pack u_round_pack (
    .sign   (sign_q),
    .exp    (exp_q),
    .mant   (mant_q),
    .result (packed_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 16'h0000;
      busy   <= 1'b0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sign_q <= in_sign;
            exp_q  <= (in_exp == '0) ? 6'd1 : in_exp;
            mant_q <= in_mant;
            done   <= 1'b0;
            busy   <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            result <= 16'h0000;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (mant_q[CARRY]) begin
            // Right shift folds the dropped bit into sticky.
            mant_q <= {1'b0, mant_q[CARRY:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + 6'd1;
          end else if (!mant_q[HID] && exp_q > 6'd1) begin
            mant_q <= {mant_q[CARRY-1:0], 1'b0};
            exp_q  <= exp_q - 6'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          result <= packed_w;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/flt_norm_round.md
Name: flt_norm_round

Overview:
- Sequential post-add normalize/round/pack stage of the FP16 add datapath.
- Consumes the unpacked sign, biased exponent and extended-precision mantissa from the align/add stage.
- Normalizes with one shift per cycle, rounds to nearest-even, and packs a 16-bit half-precision word for data memory bytes 132/133.
- Uses the same start/done handshake as the rest of the fltflt flow.

Parameters:
- EXP_W, 5, packed exponent field width.
- FRAC_W, 10, packed fraction width.
- BIAS, 15, exponent bias; also the exponent-field value for 1.0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  request; sampled in IDLE or DONE.
- in_sign  in  1  sign of the sum.
- in_exp  in  EXP_W+1  biased exponent of the sum; 0 is treated as 1 (subnormal scale).
- in_mant  in  FRAC_W+5  extended mantissa: [14] carry, [13] hidden, [12:3] fraction, [2] guard, [1] round, [0] sticky.
- done  out  1  level; high while result is valid, held until the next accepted start.
- result  out  16  packed FP16 {sign, exp[4:0], frac[9:0]}.
- busy  out  1  high in NORM and ROUND.

Behaviour:
- Reset: state = IDLE; done = 0, result = 16'h0000, busy = 0. Reset wins over start and aborts any operation mid-stream; no partial result is visible.
- IDLE/DONE + start: capture the inputs into internal regs (exp 0 loaded as 1), drop done, go to NORM. result keeps its old value until the new pack.
- NORM (one action per cycle, priority order):
  1. mant == 0: result = 16'h0000 (+0 regardless of sign), go to DONE.
  2. mant[14] set: shift right 1, bit0 |= shifted-out bit (sticky), exp+1, stay in NORM.
  3. mant[13] clear and exp > 1: shift left 1 with zero in, exp−1, stay in NORM.
  4. Otherwise go to ROUND.
- Shift bounds: at most 1 right shift; at most 13 left shifts. Left shifting stops at exp == 1 with hidden bit 0, which produces a subnormal result.
- ROUND:
  - lsb = mant[3]; inc = mant[2] & (mant[1] | mant[0] | lsb).
  - m11 = mant[13:3] + inc, computed 12 bits wide.
  - If m11 carries to bit 11: m11 >>= 1 and exp+1. A subnormal that rounds up to hidden = 1 becomes normal with exp 1.
  - Pack:
    - exp ≥ 31: result = {sign, 5'h1F, 10'h0} (infinity).
    - hidden 0: exp field = 0 (subnormal).
    - else: {sign, exp[4:0], m11[9:0]}.
  - Go to DONE.
- DONE: done = 1, result stable.
- Latency, counted in rising edges from the start-sampling edge to done visible:
  - 3 + k, where k is the number of NORM shifts.
  - Zero mantissa: 2.
  - Maximum: 16.
- start while busy is ignored. start in DONE on the same cycle as reset: reset wins.
- Arithmetic: exp is held in 6-bit unsigned internally, so no wrap occurs. Inputs must satisfy in_exp ≤ 31.

Decomposition:
- Shared package flt_pkg holds:
  - EXP_W, FRAC_W, BIAS, EXP_INF = 31.
  - Mantissa bit-index constants (CARRY, HID, G, R, S).
  - The state enum {IDLE, NORM, ROUND, DONE}.
- One sub-module, flt_round_pack: combinational RNE increment, round-carry renormalize, and inf/subnormal packing. Instantiated in the ROUND state logic.

Test Plan:
- Carry normalize: sign 0, in_exp 15, in_mant = 15'b11_0000000000_000 (1.5 + 1.5) -> result 16'h4200, done after 4 edges.
- Deep cancellation: in_exp 20, in_mant = 15'b00_0000000001_000 -> 10 left shifts, result 16'h2800, done after 13 edges.
- RNE ties, in_exp 15:
  - frac 0, G = 1, R = S = 0 -> 16'h3C00.
  - frac 10'h001, G = 1 -> 16'h3C02.
  - frac 10'h3FF, G = 1 -> round carry -> 16'h4000.
- Overflow and subnormal:
  - in_exp 30 with carry set, sign 1 -> 16'hFC00.
  - in_exp 1, hidden 0, frac 10'h155 -> 16'h0155.
- Zero and reset:
  - in_mant 0, sign 1 -> 16'h0000, done after 2 edges.
  - Assert reset 2 cycles into a 10-shift NORM -> done = 0, result = 0, next start completes normally.
- Handshake: start pulsed during NORM is ignored; start in DONE drops done on the next edge and a new result follows at the computed latency.
